sched_dispatch_ctrl: RTL and testbench

- Sequencer between the scheduler's 16-bit message stream and the core broadcast bus.
- Accepts one task frame in this order: header, core mask, r0 mask, R0 data words, instruction-fetch words.
- Drives the one-hot load strobes core_mask_loading, r0_mask_loading, r0_loading and if_loading that the cores latch on.
- Tracks busy cores and applies acquire/release fences before each dispatch.

---
 rtl/sched_pkg.sv | 36 +++
 rtl/sched_dispatch_ctrl_busy.sv | 52 +++++
 rtl/sched_dispatch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sched_dispatch_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types for the scheduler dispatch sequencer: FSM states, header field
// layout, fence codes and the one-hot load strobe encoding.
package sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MASK,
        S_CHECK,
        S_R0MASK,
        S_R0DATA,
        S_IFETCH,
        S_FINISH
    } state_e;

    // Header layout: if_num sits in the low bits, fence in [7:6].
    localparam int HDR_FENCE_LSB = 6;
    localparam int HDR_FENCE_W   = 2;

    localparam logic [HDR_FENCE_W-1:0] FENCE_NONE = 2'd0;
    localparam logic [HDR_FENCE_W-1:0] FENCE_ACQ  = 2'd1;
    localparam logic [HDR_FENCE_W-1:0] FENCE_REL  = 2'd2;

    // Bit order matches {if_loading, r0_loading, r0_mask_loading, core_mask_loading}.
    typedef enum logic [3:0] {
        STB_NONE   = 4'b0000,
        STB_CMASK  = 4'b0001,
        STB_R0MASK = 4'b0010,
        STB_R0     = 4'b0100,
        STB_IF     = 4'b1000
    } strobe_e;

    function automatic logic [HDR_FENCE_W-1:0] hdr_fence(input logic [15:0] w);
        return w[HDR_FENCE_LSB +: HDR_FENCE_W];
    endfunction

endpackage

// File: rtl/sched_dispatch_ctrl_busy.sv
// Busy/acquire bookkeeping for the dispatch sequencer; produces the
// combinational dispatch-allow for the frame waiting in CHECK.
module core_busy_tracker
    import sched_pkg::*;
#(
    parameter int CORE_NUM = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CORE_NUM-1:0] core_done_i,
    input  logic                set_en_i,
    input  logic [CORE_NUM-1:0] set_mask_i,
    input  logic                set_acq_i,
    input  logic                rel_i,
    input  logic [CORE_NUM-1:0] chk_mask_i,
    output logic [CORE_NUM-1:0] busy_mask_o,
    output logic                allow_o
);

    logic [CORE_NUM-1:0] busy_q, busy_d;
    logic [CORE_NUM-1:0] acq_q, acq_d;
    logic [CORE_NUM-1:0] busy_clr;

    // Completions landing this cycle already count toward the allow decision.
    assign busy_clr = busy_q & ~core_done_i;

    always_comb begin
        busy_d = busy_clr;
        acq_d  = acq_q & ~core_done_i;
        if (set_en_i) begin
            busy_d = busy_clr | set_mask_i;
            acq_d  = set_acq_i ? set_mask_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            acq_q  <= '0;
        end else begin
            busy_q <= busy_d;
            acq_q  <= acq_d;
        end
    end

    assign allow_o = ~|(chk_mask_i & busy_clr)
                   & (~rel_i | ~|busy_clr)
                   & ~|(acq_q & busy_clr);

    assign busy_mask_o = busy_q;

endmodule

// File: rtl/sched_dispatch_ctrl.sv
// Scheduler-to-core frame sequencer: header, core mask, r0 mask, R0 data and
// instruction words onto a registered broadcast bus with one-hot load strobes.
// Optional CHECK-wait watchdog enabled by defining SCHED_FENCE_TIMEOUT_EN.
module sched_dispatch_ctrl
    import sched_pkg::*;
#(
    parameter int MSG_WIDTH     = 16,
    parameter int CORE_NUM      = 16,
    parameter int R0_DEPTH      = 8,
    parameter int IF_WORDS      = 16,
    parameter int IFNUM_W       = 6,
    parameter int FENCE_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 msg_valid,
    input  logic [MSG_WIDTH-1:0] msg_data,
    output logic                 msg_ready,
    input  logic [CORE_NUM-1:0]  core_done,
    output logic [MSG_WIDTH-1:0] bus_data,
    output logic                 core_mask_loading,
    output logic                 r0_mask_loading,
    output logic                 r0_loading,
    output logic                 if_loading,
    output logic [CORE_NUM-1:0]  busy_mask,
    output logic                 frame_done,
    output logic                 fence_stall,
    output logic                 timeout_err
);

    localparam int IFCNT_W = IFNUM_W + $clog2(IF_WORDS);
    localparam int R0CNT_W = (R0_DEPTH > 1) ? $clog2(R0_DEPTH) : 1;
    localparam int CNT_W   = (IFCNT_W > R0CNT_W) ? IFCNT_W : R0CNT_W;
    localparam logic [CNT_W-1:0] R0_LAST = CNT_W'(R0_DEPTH - 1);

    state_e                  state_q;
    logic [IFNUM_W-1:0]      if_num_q;
    logic [HDR_FENCE_W-1:0]  fence_q;
    logic [CORE_NUM-1:0]     core_mask_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [MSG_WIDTH-1:0]    bus_data_q;
    strobe_e                 strobe_q;
    logic                    frame_done_q;

    logic                    allow;
    logic                    accept;
    logic [CNT_W-1:0]        if_last;
    state_e                  after_r0;

    assign msg_ready = (state_q == S_IDLE)   || (state_q == S_MASK)   ||
                       (state_q == S_R0MASK) || (state_q == S_R0DATA) ||
                       (state_q == S_IFETCH);
    assign accept      = msg_valid & msg_ready;
    assign fence_stall = (state_q == S_CHECK) & ~allow;
    assign if_last     = CNT_W'(if_num_q) * CNT_W'(IF_WORDS) - CNT_W'(1);
    assign after_r0    = (if_num_q == '0) ? S_FINISH : S_IFETCH;

    core_busy_tracker #(
        .CORE_NUM (CORE_NUM)
    ) u_busy (
        .clk_i       (clk),
        .rst_ni      (reset),
        .core_done_i (core_done),
        .set_en_i    (state_q == S_FINISH),
        .set_mask_i  (core_mask_q),
        .set_acq_i   (fence_q == FENCE_ACQ),
        .rel_i       (fence_q == FENCE_REL),
        .chk_mask_i  (core_mask_q),
        .busy_mask_o (busy_mask),
        .allow_o     (allow)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            if_num_q     <= '0;
            fence_q      <= FENCE_NONE;
            core_mask_q  <= '0;
            cnt_q        <= '0;
            bus_data_q   <= '0;
            strobe_q     <= STB_NONE;
            frame_done_q <= 1'b0;
        end else begin
            strobe_q     <= STB_NONE;
            frame_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (accept) begin
                    if_num_q <= msg_data[IFNUM_W-1:0];
                    fence_q  <= hdr_fence(16'(msg_data));
                    state_q  <= S_MASK;
                end
                S_MASK: if (accept) begin
                    core_mask_q <= msg_data[CORE_NUM-1:0];
                    state_q     <= S_CHECK;
                end
                S_CHECK: if (allow) begin
                    bus_data_q <= MSG_WIDTH'(core_mask_q);
                    strobe_q   <= STB_CMASK;
                    state_q    <= S_R0MASK;
                end
                S_R0MASK: if (accept) begin
                    bus_data_q <= msg_data;
                    strobe_q   <= STB_R0MASK;
                    cnt_q      <= '0;
                    if (msg_data != '0) begin
                        state_q <= S_R0DATA;
                    end else begin
                        state_q      <= after_r0;
                        frame_done_q <= (after_r0 == S_FINISH);
                    end
                end
                S_R0DATA: if (accept) begin
                    bus_data_q <= msg_data;
                    strobe_q   <= STB_R0;
                    if (cnt_q == R0_LAST) begin
                        cnt_q        <= '0;
                        state_q      <= after_r0;
                        frame_done_q <= (after_r0 == S_FINISH);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_IFETCH: if (accept) begin
                    bus_data_q <= msg_data;
                    strobe_q   <= STB_IF;
                    if (cnt_q == if_last) begin
                        cnt_q        <= '0;
                        state_q      <= S_FINISH;
                        frame_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_data   = bus_data_q;
    assign frame_done = frame_done_q;
    assign {if_loading, r0_loading, r0_mask_loading, core_mask_loading} = strobe_q;

`ifdef SCHED_FENCE_TIMEOUT_EN
    localparam int TO_W = $clog2(FENCE_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_err_q;

    // Saturating stall counter; the error flag stays set while CHECK keeps waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q != S_CHECK)
                to_cnt_q <= '0;
            else if (fence_stall && to_cnt_q != TO_W'(FENCE_TIMEOUT))
                to_cnt_q <= to_cnt_q + TO_W'(1);
            if (fence_stall && to_cnt_q == TO_W'(FENCE_TIMEOUT - 1))
                timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_cfg;
    assign unused_cfg  = (FENCE_TIMEOUT > 0);
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sched_dispatch_ctrl.sv
// Scoreboard bench for sched_dispatch_ctrl: stimulus queues expected bus words,
// a negedge monitor pops and compares every emission and frame_done pulse.
`timescale 1ns/1ps
module tb_sched_dispatch_ctrl;

`ifdef SCHED_FENCE_TIMEOUT_EN
    localparam int FT = 16;
`else
    localparam int FT = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        msg_valid = 1'b0;
    logic [15:0] msg_data = '0;
    logic        msg_ready;
    logic [15:0] core_done = '0;
    logic [15:0] bus_data;
    logic        core_mask_loading, r0_mask_loading, r0_loading, if_loading;
    logic [15:0] busy_mask;
    logic        frame_done, fence_stall, timeout_err;

    always #5 clk = ~clk;

    sched_dispatch_ctrl #(
        .MSG_WIDTH(16), .CORE_NUM(16), .R0_DEPTH(8), .IF_WORDS(16),
        .IFNUM_W(6), .FENCE_TIMEOUT(FT)
    ) dut (
        .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_data(msg_data),
        .msg_ready(msg_ready), .core_done(core_done), .bus_data(bus_data),
        .core_mask_loading(core_mask_loading), .r0_mask_loading(r0_mask_loading),
        .r0_loading(r0_loading), .if_loading(if_loading), .busy_mask(busy_mask),
        .frame_done(frame_done), .fence_stall(fence_stall), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [4:0]  kind;
        logic [15:0] data;
    } exp_t;

    localparam logic [4:0] K_NONE = 5'h00, K_CM = 5'h01, K_RM = 5'h02,
                           K_R0 = 5'h04, K_IF = 5'h08, K_FD = 5'h10;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the queue.
    logic [3:0] stb;
    exp_t       e;
    always @(negedge clk) begin
        if (reset) begin
            stb = {if_loading, r0_loading, r0_mask_loading, core_mask_loading};
            if (stb != 4'b0) begin
                if (q.size() == 0 || q[0].kind == K_FD) begin
                    check("unexpected_emission", {12'h0, stb, bus_data}, 32'h0);
                end else begin
                    e = q.pop_front();
                    check("emission", {12'h0, stb, bus_data}, {12'h0, e.kind[3:0], e.data});
                    if (q.size() != 0 && q[0].kind == K_FD) begin
                        void'(q.pop_front());
                        check("frame_done", {31'h0, frame_done}, 32'h1);
                    end else if (frame_done) begin
                        check("spurious_frame_done", {31'h0, frame_done}, 32'h0);
                    end
                end
            end else if (frame_done) begin
                check("frame_done_without_word", {31'h0, frame_done}, 32'h0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send(input logic [15:0] w, input logic [4:0] k, input logic fd);
        int n;
        if (k != K_NONE) q.push_back('{kind: k, data: w});
        if (fd) q.push_back('{kind: K_FD, data: 16'h0});
        msg_valid = 1'b1;
        msg_data  = w;
        n = 0;
        while (!msg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!msg_ready) begin
            check("ready_wait_expired", {31'h0, msg_ready}, 32'h1);
            msg_valid = 1'b0;
            return;
        end
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] hdr, input logic [15:0] mask, input logic [15:0] r0m);
        int nr0, nif;
        nr0 = (r0m != 16'h0) ? 8 : 0;
        nif = int'(hdr[5:0]) * 16;
        send(hdr, K_NONE, 1'b0);
        send(mask, K_CM, 1'b0);
        send(r0m, K_RM, (nr0 == 0 && nif == 0));
        for (int i = 0; i < nr0; i++)
            send(16'(16'h1000 + i), K_R0, (i == nr0 - 1 && nif == 0));
        for (int i = 0; i < nif; i++)
            send(16'(16'h2000 + i), K_IF, (i == nif - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic done_pulse(input logic [15:0] m);
        core_done = m;
        @(negedge clk);
        core_done = '0;
    endtask

    initial begin
        idle(2);
        check("rst_bus_data", {16'h0, bus_data}, 32'h0);
        check("rst_strobes", {28'h0, if_loading, r0_loading, r0_mask_loading, core_mask_loading}, 32'h0);
        check("rst_busy", {16'h0, busy_mask}, 32'h0);
        check("rst_ready", {31'h0, msg_ready}, 32'h1);
        check("rst_misc", {29'h0, frame_done, fence_stall, timeout_err}, 32'h0);
        reset = 1'b1;
        idle(1);

        // Full frame with R0 data and two fetch blocks
        run_frame(16'h0002, 16'h000F, 16'h0003);
        idle(3);
        check("t1_busy", {16'h0, busy_mask}, 32'h000F);
        check("t1_drained", q.size(), 32'h0);
        check("t1_bus_hold", {16'h0, bus_data}, 32'h201F);

        // Overlapping mask stalls until its core completes
        done_pulse(16'h000E);
        check("t2_busy_pre", {16'h0, busy_mask}, 32'h0001);
        send(16'h0000, K_NONE, 1'b0);
        send(16'h0003, K_CM, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t2_stall", {31'h0, fence_stall}, 32'h1);
            check("t2_no_emit", {31'h0, core_mask_loading}, 32'h0);
            idle(1);
        end
        done_pulse(16'h0001);
        check("t2_emit_after_done", {31'h0, core_mask_loading}, 32'h1);
        send(16'h0000, K_RM, 1'b1);
        idle(2);
        check("t2_busy_post", {16'h0, busy_mask}, 32'h0003);
        done_pulse(16'h0003);

        // Acquire fence blocks a disjoint frame until every acquiring core is done
        run_frame(16'h0040, 16'h00F0, 16'h0000);
        idle(2);
        check("t3_busy_a", {16'h0, busy_mask}, 32'h00F0);
        send(16'h0000, K_NONE, 1'b0);
        send(16'h0F00, K_CM, 1'b0);
        idle(2);
        check("t3_stall", {31'h0, fence_stall}, 32'h1);
        done_pulse(16'h0030);
        check("t3_still_stall", {31'h0, fence_stall}, 32'h1);
        check("t3_busy_part", {16'h0, busy_mask}, 32'h00C0);
        check("t3_no_emit", {31'h0, core_mask_loading}, 32'h0);
        done_pulse(16'h00C0);
        check("t3_emit", {31'h0, core_mask_loading}, 32'h1);
        send(16'h0000, K_RM, 1'b1);
        idle(2);
        check("t3_busy_b", {16'h0, busy_mask}, 32'h0F00);
        done_pulse(16'h0F00);

        // Empty frame with valid gaps; completion in FINISH loses to the set
        send(16'h0000, K_NONE, 1'b0);
        idle(1);
        send(16'h0001, K_CM, 1'b0);
        idle(1);
        send(16'h0000, K_RM, 1'b1);
        done_pulse(16'h0001);
        check("t4_set_wins", {16'h0, busy_mask}, 32'h0001);
        idle(2);
        check("t4_drained", q.size(), 32'h0);
        done_pulse(16'h0001);

        // Reset during fetch word 5 drops the frame
        send(16'h0001, K_NONE, 1'b0);
        send(16'h0002, K_CM, 1'b0);
        send(16'h0000, K_RM, 1'b0);
        for (int i = 0; i < 5; i++) send(16'(16'h3000 + i), K_IF, 1'b0);
        msg_valid = 1'b1;
        msg_data  = 16'h3005;
        #2 reset = 1'b0;
        #1;
        check("t5_rst_bus", {16'h0, bus_data}, 32'h0);
        check("t5_rst_strobes", {28'h0, if_loading, r0_loading, r0_mask_loading, core_mask_loading}, 32'h0);
        check("t5_rst_ready", {31'h0, msg_ready}, 32'h1);
        check("t5_drained", q.size(), 32'h0);
        msg_valid = 1'b0;
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        run_frame(16'h0001, 16'h0004, 16'h0001);
        idle(3);
        check("t5_fresh_busy", {16'h0, busy_mask}, 32'h0004);
        check("t5_fresh_drained", q.size(), 32'h0);

        // Largest if_num: 1008 fetch words, no counter wrap
        run_frame(16'h003F, 16'h0100, 16'h0000);
        idle(3);
        check("t6_busy", {16'h0, busy_mask}, 32'h0104);
        check("t6_last_word", {16'h0, bus_data}, 32'h23EF);
        check("t6_drained", q.size(), 32'h0);

        // Release fence waits for all cores; watchdog when built in
        send(16'h0080, K_NONE, 1'b0);
        send(16'h0001, K_CM, 1'b0);
        idle(10);
        check("t7_stall_early", {31'h0, fence_stall}, 32'h1);
        check("t7_err_early", {31'h0, timeout_err}, 32'h0);
        idle(10);
        check("t7_stall_late", {31'h0, fence_stall}, 32'h1);
`ifdef SCHED_FENCE_TIMEOUT_EN
        check("t7_err_late", {31'h0, timeout_err}, 32'h1);
`else
        check("t7_err_late", {31'h0, timeout_err}, 32'h0);
`endif
        done_pulse(16'hFFFF);
        check("t7_emit", {31'h0, core_mask_loading}, 32'h1);
        send(16'h0000, K_RM, 1'b1);
        idle(2);
        check("t7_busy", {16'h0, busy_mask}, 32'h0001);
`ifdef SCHED_FENCE_TIMEOUT_EN
        check("t7_err_sticky", {31'h0, timeout_err}, 32'h1);
`endif
        #2 reset = 1'b0;
        #1;
        check("t7_err_cleared", {31'h0, timeout_err}, 32'h0);
        check("t7_busy_cleared", {16'h0, busy_mask}, 32'h0);
        check("final_drained", q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
